// File: rtl/wb_ram512x8_bridge.sv
// wb_ram512x8_bridge: Wishbone-classic 32-bit slave that turns each word access
// into four sequential little-endian byte accesses on a ram512x8 SRAM.
module wb_ram512x8_bridge #(
    parameter int RAM_AW = 9
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [RAM_AW-1:0] wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              ram_cen_o,
    output logic              ram_wen_o,
    output logic [RAM_AW-1:0] ram_adr_o,
    output logic [7:0]        ram_dat_o,
    input  logic [7:0]        ram_dat_i
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // RAM outputs are purely combinational so an asynchronous reset idles them at once
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        ram_cen_o = 1'b1;
        ram_wen_o = 1'b0;
        ram_adr_o = '0;
        ram_dat_o = 8'd0;
        wb_ack_o  = 1'b0;
        wb_dat_o  = 32'd0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_d = ACCESS;
                    cnt_d   = 2'd0;
                end
            end
            ACCESS: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    ram_adr_o = {wb_adr_i[RAM_AW-1:2], cnt_q};
                    ram_dat_o = wb_dat_i[8*cnt_q +: 8];
                    ram_cen_o = wb_we_i ? ~wb_sel_i[cnt_q] : 1'b0;
                    ram_wen_o = wb_we_i & wb_sel_i[cnt_q];
                    // RAM data lags its access by one cycle, so byte cnt-1 arrives now
                    if (!wb_we_i && cnt_q != 2'd0)
                        buf_d[8*(cnt_q-2'd1) +: 8] = ram_dat_i;
                    cnt_d   = cnt_q + 2'd1;
                    state_d = (cnt_q == 2'd3) ? DONE : ACCESS;
                end
            end
            DONE: begin
                wb_ack_o = 1'b1;
                wb_dat_o = wb_we_i ? 32'd0 : {ram_dat_i, buf_q};
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_wb_ram512x8_bridge.sv
// tb_wb_ram512x8_bridge: directed and randomized checks of the bridge against
// a byte-array reference model, with a behavioural ram512x8 attached.
module tb_wb_ram512x8_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [8:0]  adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] dat_o;
    logic        ack, cen, wen;
    logic [8:0]  ram_adr;
    logic [7:0]  ram_wd;
    logic [7:0]  ram_rd = 8'd0;
    logic [7:0]  mem [512];
    logic [7:0]  ref_mem [512];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    wb_ram512x8_bridge #(.RAM_AW(9)) dut (
        .clk_i(clk), .rst_in(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
        .wb_dat_o(dat_o), .wb_ack_o(ack),
        .ram_cen_o(cen), .ram_wen_o(wen), .ram_adr_o(ram_adr),
        .ram_dat_o(ram_wd), .ram_dat_i(ram_rd)
    );

    // ram512x8: synchronous, read data appears the cycle after the access edge
    always @(posedge clk) begin
        if (!cen) begin
            if (wen) mem[ram_adr] <= ram_wd;
            else     ram_rd <= mem[ram_adr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [8:0] a);
        int b;
        b = int'({a[8:2], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // abort_at = byte index whose ACCESS cycle sees cyc low; 4 = no abort
    task automatic xfer(input logic w, input logic [8:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int abort_at, output logic [31:0] r);
        logic [8:0] ba;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        @(negedge clk);
        check("c0_ack", 32'(ack), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == abort_at) begin cyc = 1'b0; stb = 1'b0; end
            @(negedge clk);
            check("acc_ack", 32'(ack), 32'd0);
            check("acc_dat_o", dat_o, 32'd0);
            if (k >= abort_at) begin
                check("abort_cen", 32'(cen), 32'd1);
            end else begin
                ba = {a[8:2], 2'b00} + 9'(k);
                check("ram_adr", 32'(ram_adr), 32'(ba));
                check("ram_cen", 32'(cen), (w && !s[k]) ? 32'd1 : 32'd0);
                check("ram_wen", 32'(wen), (w && s[k]) ? 32'd1 : 32'd0);
                if (w && s[k]) begin
                    check("ram_wdat", 32'(ram_wd), 32'(d[8*k +: 8]));
                    ref_mem[ba] = d[8*k +: 8];
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("done_ack", 32'(ack), (abort_at >= 4) ? 32'd1 : 32'd0);
        check("done_cen", 32'(cen), 32'd1);
        check("done_dat_o", dat_o, (abort_at >= 4 && !w) ? ref_word(a) : 32'd0);
        r = dat_o;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("post_ack", 32'(ack), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin mem[i] = 8'd0; ref_mem[i] = 8'd0; end
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; sel = '0; wdat = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat_o", dat_o, 32'd0);
        check("rst_cen", 32'(cen), 32'd1);
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_adr", 32'(ram_adr), 32'd0);
        check("rst_wdat", 32'(ram_wd), 32'd0);
        rst_n = 1'b1;

        xfer(1'b1, 9'h010, 4'hF, 32'hDEADBEEF, 4, rd);
        xfer(1'b0, 9'h010, 4'h0, 32'h0, 4, rd);
        check("rb_deadbeef", rd, 32'hDEADBEEF);

        xfer(1'b1, 9'h020, 4'hF, 32'h11223344, 4, rd);
        xfer(1'b1, 9'h020, 4'b0101, 32'hAABBCCDD, 4, rd);
        xfer(1'b0, 9'h020, 4'h0, 32'h0, 4, rd);
        check("rb_sel0101", rd, 32'h11BB33DD);

        xfer(1'b1, 9'h1FC, 4'hF, 32'h01020304, 4, rd);
        xfer(1'b0, 9'h1FF, 4'h0, 32'h0, 4, rd);
        check("rb_top", rd, 32'h01020304);
        xfer(1'b0, 9'h000, 4'h0, 32'h0, 4, rd);
        check("rb_zero_nowrap", rd, 32'h0);

        xfer(1'b1, 9'h040, 4'hF, 32'hCAFEF00D, 2, rd);
        xfer(1'b0, 9'h040, 4'h0, 32'h0, 4, rd);
        check("rb_abort", rd, 32'h0000F00D);

        // back-to-back reads with strobe held high
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 9'h010;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check("b2b_ack", 32'(ack), (i == 5 || i == 11) ? 32'd1 : 32'd0);
            check("b2b_dat_o", dat_o, (i == 5 || i == 11) ? 32'hDEADBEEF : 32'd0);
            @(posedge clk); #1;
            if (i == 11) begin cyc = 1'b0; stb = 1'b0; end
        end

        // asynchronous reset in C3 of a read
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 9'h020;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_wen", 32'(wen), 32'd0);
        check("arst_cen", 32'(cen), 32'd1);
        check("arst_adr", 32'(ram_adr), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 9'h020, 4'h0, 32'h0, 4, rd);
        check("arst_rb", rd, 32'h11BB33DD);

        for (int n = 0; n < 30; n++) begin
            logic [8:0] ra;
            ra = {2'b10, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom_range(0, 3))};
            xfer(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : 4, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
